// File: rtl/fetch_to_decode_transmitter.sv
// Fetch-side driver of the fetch-to-decode bus.
// Buffers (pc, insn) pairs from the fetch unit in a small FIFO, tags each
// entry with a wrapping sequence number, and issues one-cycle send strobes
// carrying {tag, pc, insn} whenever the bus is free.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   fetch_valid/_ready  - fetch handshake; fetch_pc/fetch_insn are the payload
//   flush               - branch redirect: drop buffered entries, restart tag
//   bus_is_busy         - bus still holds an unconsumed packet
//   bus_send/bus_data   - registered one-cycle strobe and packet {tag,pc,insn}
//   occupancy           - current FIFO count
//   stall_cycles        - saturating count of cycles blocked by bus_is_busy
module fetch_to_decode_transmitter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INSN_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              fetch_valid,
  input  logic [ADDR_W-1:0]                 fetch_pc,
  input  logic [INSN_W-1:0]                 fetch_insn,
  output logic                              fetch_ready,
  input  logic                              flush,
  input  logic                              bus_is_busy,
  output logic                              bus_send,
  output logic [TAG_W+ADDR_W+INSN_W-1:0]    bus_data,
  output logic [$clog2(DEPTH):0]            occupancy,
  output logic [15:0]                       stall_cycles
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PKT_W = TAG_W + ADDR_W + INSN_W;

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             send_q, send_d;
  logic [PKT_W-1:0] data_q, data_d;
  logic [15:0]      stall_q, stall_d;

  logic push;
  logic fire;

  always_comb begin
    fetch_ready = (occ_q < CNT_W'(DEPTH)) && !flush;
    push        = fetch_valid && fetch_ready;
    // No fire while our own strobe is out: the bus only raises busy on the
    // edge after the strobe, so firing back-to-back would overwrite it.
    fire        = (occ_q != '0) && !bus_is_busy && !flush && !send_q;

    rd_d    = rd_q;
    wr_d    = wr_q;
    occ_d   = occ_q;
    tag_d   = tag_q;
    send_d  = fire;
    data_d  = data_q;
    stall_d = stall_q;

    if (push) begin
      wr_d  = wr_q + PTR_W'(1);
      tag_d = tag_q + TAG_W'(1);
    end
    if (fire) begin
      rd_d   = rd_q + PTR_W'(1);
      data_d = mem_q[rd_q];
    end
    case ({push, fire})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    // push and fire are already suppressed during flush; only the
    // bookkeeping needs clearing. bus_data keeps the last delivered packet.
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      occ_d = '0;
      tag_d = '0;
    end

    if ((occ_q != '0) && bus_is_busy && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      tag_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      occ_q   <= occ_d;
      tag_q   <= tag_d;
      send_q  <= send_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_q] <= {tag_q, fetch_pc, fetch_insn};
    end
  end

  assign bus_send     = send_q;
  assign bus_data     = data_q;
  assign occupancy    = occ_q;
  assign stall_cycles = stall_q;

endmodule
